// File: rtl/mux_arbiter4.sv
// ============================================================================
// Module   : mux_arbiter4
// Brief    : Four-requester round-robin arbiter driving a shared 4-to-1 mux.
//            Grants are held until the owner drops its request or, when
//            another requester is waiting, until MAX_HOLD beats are accepted.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_arbiter4 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic [3:0] i_Request,
    input  logic       i_Ready,
    output logic [3:0] o_Grant,
    output logic [1:0] o_Select,
    output logic       o_Valid,
    output logic [3:0] o_Accept
);

    // Beat counter must be at least 5 bits and wide enough to reach MAX_HOLD.
    localparam int c_CNT_W = ($clog2(MAX_HOLD + 1) > 5) ? $clog2(MAX_HOLD + 1) : 5;
    localparam logic [c_CNT_W-1:0] c_HOLD    = c_CNT_W'(MAX_HOLD);
    // With an unlimited hold the counter simply parks at all-ones.
    localparam logic [c_CNT_W-1:0] c_CNT_SAT = (MAX_HOLD == 0) ? {c_CNT_W{1'b1}} : c_HOLD;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t               r_state_q;
    logic [3:0]           r_grant_q;
    logic [1:0]           r_sel_q;
    logic [1:0]           r_ptr_q;
    logic [c_CNT_W-1:0]   r_cnt_q;

    logic [1:0]           w_srch_ptr;
    logic [3:0]           w_srch_req;
    logic [1:0]           w_idx;
    logic [1:0]           w_win;
    logic                 w_found;
    logic                 w_busy;
    logic                 w_beat;
    logic [c_CNT_W-1:0]   w_cnt_d;
    logic                 w_drop;
    logic                 w_quota;
    logic                 w_release;

    assign w_busy = (r_state_q == ST_BUSY);
    assign w_beat = w_busy && i_Ready;

    // Saturating count that includes the beat being accepted this cycle.
    assign w_cnt_d = (w_beat && (r_cnt_q != c_CNT_SAT)) ? (r_cnt_q + c_CNT_W'(1)) : r_cnt_q;

    // Owner gave up, or its quota ran out while somebody else is waiting.
    assign w_drop    = ~i_Request[r_sel_q];
    assign w_quota   = (MAX_HOLD != 0) && (w_cnt_d == c_HOLD) && (|(i_Request & ~r_grant_q));
    assign w_release = w_busy && (w_drop || w_quota);

    // Round-robin search: in BUSY it is only consumed on release, so it always
    // uses the post-release pointer and masks out the current owner.
    always_comb begin
        w_srch_ptr = r_ptr_q;
        w_srch_req = i_Request;
        if (w_busy) begin
            w_srch_ptr = r_sel_q + 2'd1;
            w_srch_req = i_Request & ~r_grant_q;
        end
        w_found = 1'b0;
        w_win   = w_srch_ptr;
        w_idx   = 2'd0;
        // Scan from farthest to nearest so the nearest set bit wins.
        for (int i = 3; i >= 0; i--) begin
            w_idx = w_srch_ptr + 2'(i);
            if (w_srch_req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    // Arbitration state machine with registered grant, select and pointer.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_state_q <= ST_IDLE;
            r_grant_q <= 4'b0000;
            r_sel_q   <= 2'd0;
            r_ptr_q   <= 2'd0;
            r_cnt_q   <= '0;
        end else begin
            case (r_state_q)
                ST_IDLE: begin
                    if (w_found) begin
                        r_state_q <= ST_BUSY;
                        r_grant_q <= 4'b0001 << w_win;
                        r_sel_q   <= w_win;
                        r_cnt_q   <= '0;
                    end
                end
                ST_BUSY: begin
                    if (w_release) begin
                        r_ptr_q <= r_sel_q + 2'd1;
                        if (w_found) begin
                            r_grant_q <= 4'b0001 << w_win;
                            r_sel_q   <= w_win;
                            r_cnt_q   <= '0;
                        end else begin
                            r_state_q <= ST_IDLE;
                            r_grant_q <= 4'b0000;
                        end
                    end else begin
                        r_cnt_q <= w_cnt_d;
                    end
                end
                default: begin
                    r_state_q <= ST_IDLE;
                    r_grant_q <= 4'b0000;
                end
            endcase
        end
    end

    assign o_Grant  = r_grant_q;
    assign o_Select = r_sel_q;
    assign o_Valid  = w_busy;
    assign o_Accept = r_grant_q & {4{i_Ready}};

endmodule

`default_nettype wire

// File: tb/tb_mux_arbiter4.sv
// ============================================================================
// Module   : tb_mux_arbiter4
// Brief    : Self-checking bench for mux_arbiter4 with a cycle-level model
//            and directed scenarios carrying hand-computed expectations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_arbiter4;

    localparam int MAX_HOLD = 4;

    logic       clk;
    logic       i_Reset;
    logic [3:0] i_Request;
    logic       i_Ready;
    logic [3:0] o_Grant;
    logic [1:0] o_Select;
    logic       o_Valid;
    logic [3:0] o_Accept;

    int n_checks = 0;
    int n_errors = 0;

    mux_arbiter4 #(.MAX_HOLD(MAX_HOLD)) dut (
        .i_Clock  (clk),
        .i_Reset  (i_Reset),
        .i_Request(i_Request),
        .i_Ready  (i_Ready),
        .o_Grant  (o_Grant),
        .o_Select (o_Select),
        .o_Valid  (o_Valid),
        .o_Accept (o_Accept)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        int busy;
        int own;
        int sel;
        int ptr;
        int cnt;
    } mstate_t;

    mstate_t m_st;
    bit      m_known = 1'b0;

    // First requester at or after position p, wrapping around; -1 if none.
    function automatic int pick(input int p, input logic [3:0] req);
        for (int k = 0; k < 4; k++) begin
            if (req[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    function automatic mstate_t model_next(input mstate_t s, input logic [3:0] req, input logic rdy);
        mstate_t    n;
        int         w;
        int         after;
        logic [3:0] others;
        bit         quota;
        n = s;
        if (s.busy == 0) begin
            w = pick(s.ptr, req);
            if (w >= 0) begin
                n.busy = 1; n.own = w; n.sel = w; n.cnt = 0;
            end
        end else begin
            after = s.cnt + (rdy ? 1 : 0);
            if (MAX_HOLD != 0 && after > MAX_HOLD) after = MAX_HOLD;
            others = req & ~(4'b0001 << s.own);
            quota  = (MAX_HOLD != 0) && (after == MAX_HOLD) && (others != 4'b0000);
            if (!req[s.own] || quota) begin
                n.ptr = (s.own + 1) % 4;
                w = pick(n.ptr, others);
                if (w >= 0) begin
                    n.own = w; n.sel = w; n.cnt = 0;
                end else begin
                    n.busy = 0;
                end
            end else begin
                n.cnt = after;
            end
        end
        return n;
    endfunction

    // Model advances on the same edge that the design samples its inputs.
    always @(posedge clk) begin
        if (i_Reset) begin
            m_st    <= '{busy: 0, own: 0, sel: 0, ptr: 0, cnt: 0};
            m_known <= 1'b1;
        end else if (m_known) begin
            m_st <= model_next(m_st, i_Request, i_Ready);
        end
    end

    // Compare every cycle, half a period away from the active edge.
    always @(negedge clk) begin
        logic [3:0] eg;
        if (m_known) begin
            eg = (m_st.busy != 0) ? (4'b0001 << m_st.own) : 4'b0000;
            check("model_grant",  int'(o_Grant),  int'(eg));
            check("model_select", int'(o_Select), m_st.sel);
            check("model_valid",  int'(o_Valid),  m_st.busy);
            check("model_accept", int'(o_Accept), int'(i_Ready ? eg : 4'b0000));
        end
    end

    // ---------------- directed stimulus ----------------
    // Apply inputs, let one edge sample them, then settle 2 time units.
    task automatic step(input logic [3:0] req, input logic rdy, input logic rst);
        i_Request = req;
        i_Ready   = rdy;
        i_Reset   = rst;
        @(posedge clk);
        #2;
    endtask

    initial begin
        int acc0;
        int acc1;

        // Reset state
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b1);
        check("rst_grant",  int'(o_Grant),  0);
        check("rst_select", int'(o_Select), 0);
        check("rst_valid",  int'(o_Valid),  0);

        // First grant from P=0 with 1010 goes to requester 1
        step(4'b1010, 1'b0, 1'b0);
        check("first_grant",  int'(o_Grant),  4'b0010);
        check("first_select", int'(o_Select), 1);
        check("first_valid",  int'(o_Valid),  1);

        // Owner drops, requester 3 picked up with no idle bubble
        step(4'b1000, 1'b0, 1'b0);
        check("handoff_grant",  int'(o_Grant),  4'b1000);
        check("handoff_select", int'(o_Select), 3);
        check("handoff_valid",  int'(o_Valid),  1);

        // Everyone drops: idle, select holds last value
        step(4'b0000, 1'b0, 1'b0);
        check("idle_grant",  int'(o_Grant),  0);
        check("idle_select", int'(o_Select), 3);
        check("idle_valid",  int'(o_Valid),  0);

        // Drop and new request in the same cycle: 0 -> 1 in a single arbitration
        step(4'b0001, 1'b1, 1'b0);
        step(4'b0110, 1'b1, 1'b0);
        check("swap_grant", int'(o_Grant), 4'b0010);
        step(4'b0000, 1'b0, 1'b0);

        // Reset mid-grant with select 3 and P=2, then P must be back at 0
        step(4'b0010, 1'b0, 1'b0);
        step(4'b1000, 1'b0, 1'b0);
        check("pre_rst_select", int'(o_Select), 3);
        step(4'b1000, 1'b1, 1'b1);
        check("midrst_grant",  int'(o_Grant),  0);
        check("midrst_valid",  int'(o_Valid),  0);
        check("midrst_select", int'(o_Select), 0);
        step(4'b1010, 1'b0, 1'b0);
        check("post_rst_grant", int'(o_Grant), 4'b0010);

        // Quota rotation: 0011 with ready, owners alternate every 4 beats
        step(4'b0000, 1'b0, 1'b1);
        acc0 = 0;
        acc1 = 0;
        for (int k = 1; k <= 16; k++) begin
            step(4'b0011, 1'b1, 1'b0);
            check("rot_grant", int'(o_Grant), int'(4'b0001 << (((k - 1) / 4) % 2)));
            if (k <= 8) begin
                acc0 += int'(o_Accept[0]);
                acc1 += int'(o_Accept[1]);
            end
        end
        check("rot_accept0", acc0, 4);
        check("rot_accept1", acc1, 4);

        // Lone requester 2 keeps the grant past the quota, then yields to 0
        step(4'b0000, 1'b0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            step(4'b0100, 1'b1, 1'b0);
            check("hold_grant", int'(o_Grant), 4'b0100);
        end
        step(4'b0101, 1'b1, 1'b0);
        check("yield_grant",  int'(o_Grant),  4'b0001);
        check("yield_select", int'(o_Select), 0);

        // Quota reached by a stalled saturated owner when a rival shows up
        step(4'b0001, 1'b1, 1'b0);
        step(4'b0001, 1'b1, 1'b0);
        step(4'b0001, 1'b1, 1'b0);
        step(4'b0001, 1'b1, 1'b0);
        step(4'b0001, 1'b0, 1'b0);
        step(4'b1001, 1'b0, 1'b0);
        check("stall_sat_grant", int'(o_Grant), 4'b1000);

        // No ready: no preemption and no accepts
        step(4'b0000, 1'b0, 1'b1);
        for (int k = 0; k < 12; k++) begin
            step(4'b0011, 1'b0, 1'b0);
            check("noready_grant",  int'(o_Grant),  4'b0001);
            check("noready_accept", int'(o_Accept), 0);
        end

        step(4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mux_arbiter4.md
MUX_ARBITER4 -- requirements
Module: mux_arbiter4

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 16: the maximum number of accepted beats per grant when another requester is pending; 0 means unlimited.
REQ-002 The block SHALL have port i_Clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port i_Reset, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port i_Request, input, 4 bits: bit n high means requester n wants the shared 4-to-1 datapath.
REQ-005 The block SHALL have port i_Ready, input, 1 bit: the downstream sink accepts the current beat this cycle.
REQ-006 The block SHALL have port o_Grant, output, 4 bits: one-hot owner of the datapath, or all zeros when no owner.
REQ-007 The block SHALL have port o_Select, output, 2 bits: the index of the granted requester, wired directly to the mux select.
REQ-008 The block SHALL have port o_Valid, output, 1 bit: high while a grant is active, so the mux output is a valid beat.
REQ-009 The block SHALL have port o_Accept, output, 4 bits: one-hot beat accepted for requester n, equal to o_Grant AND i_Ready.

Function
REQ-010 All outputs except o_Accept SHALL be registered; o_Accept SHALL be combinational from registered o_Grant and i_Ready.
REQ-011 The state machine SHALL have two states, IDLE and BUSY; o_Valid SHALL be 1 exactly in BUSY.
REQ-012 The block SHALL hold a 2-bit priority pointer P; the search order SHALL be P, P+1, P+2, P+3 (mod 4), and the first set bit of i_Request wins.
REQ-013 From IDLE with any i_Request bit set in cycle N, the block SHALL enter BUSY with o_Grant/o_Select of the winner in cycle N+1 (latency 1); with i_Request = 0 it SHALL stay in IDLE.
REQ-014 In BUSY, o_Grant SHALL stay one-hot and o_Select SHALL stay constant until release.
REQ-015 Beat counter: 5 bits wide minimum, enough to hold MAX_HOLD; cleared on every new grant; incremented on every cycle with o_Valid=1 and i_Ready=1; saturates at MAX_HOLD.
REQ-016 Release cause (a), evaluated in BUSY each cycle: i_Request[o_Select]=0.
REQ-017 Release cause (b), evaluated in BUSY each cycle: MAX_HOLD is non-zero, the count including the current accepted beat equals MAX_HOLD, and any other i_Request bit is set.
REQ-018 On release, P SHALL become o_Select+1 (mod 4).
REQ-019 On release, the search of REQ-012 SHALL run with the new P and with bit o_Select masked.
REQ-020 If a winner exists at release, the block SHALL grant it in the next cycle with no IDLE bubble.
REQ-021 If no winner exists at release, the block SHALL go to IDLE with o_Grant=0 in the next cycle.
REQ-022 If the count reaches MAX_HOLD and no other request is pending, the grant SHALL continue, with the count saturated, until cause (a) or until another request appears.
REQ-023 A requester dropping its request and a new request arriving in the same cycle SHALL be handled by a single arbitration per REQ-019 to REQ-021.
REQ-024 P SHALL change only on release or reset.
REQ-025 In IDLE, o_Select SHALL hold its last granted value and o_Grant SHALL be 0.
REQ-026 Requests of non-granted requesters SHALL never affect o_Grant during BUSY, except as the pending condition of REQ-017.

Reset
REQ-027 While i_Reset=1 at a clock edge, the next state SHALL be IDLE with o_Grant=0, o_Select=0, o_Valid=0, P=0 and count=0, regardless of current state, including mid-grant.
REQ-028 The first grant SHALL be possible in the cycle after the first edge with i_Reset=0.

Verification
REQ-029 The bench SHALL cover: after reset, i_Request=4'b1010 -> next cycle o_Grant=4'b0010, o_Select=1, o_Valid=1.
REQ-030 The bench SHALL cover: requester 1 granted, then i_Request drops to 4'b1000 -> next cycle o_Grant=4'b1000, o_Select=3, no IDLE cycle, P=2.
REQ-031 The bench SHALL cover: MAX_HOLD=4, i_Request=4'b0011 constant, i_Ready=1 -> grant alternates 0,1,0,1 every 4 cycles, each owner with exactly 4 o_Accept pulses.
REQ-032 The bench SHALL cover: MAX_HOLD=4, only requester 2 requesting with i_Ready=1 for 10 cycles -> grant held all 10 cycles; requester 0 then asserts -> grant moves to 0 after the next accepted beat.
REQ-033 The bench SHALL cover: i_Ready=0 throughout with two requesters -> no preemption and o_Accept=0.
REQ-034 The bench SHALL cover: i_Reset=1 mid-grant with o_Select=3 -> next cycle o_Grant=0, o_Valid=0, o_Select=0; next arbitration starts from P=0.
